mem_stage_access_unit: RTL
==========================

// Module: mem_stage_access_unit
// PURPOSE
//  MEM-stage consumer of the EX/MEM pipeline register outputs. Converts MemRead/MemWrite,
//  bytes2Load/bytes2Store, ALUResult (address) and MemWriteData into a req/ready handshake
//  to word-wide data memory. Produces LoadData for MEM/WB. Holds the pipeline via Stall
//  until the access completes. Flags misaligned accesses and memory timeouts.
// PARAMETERS
//  ADDR_W   14  word-address width; MemAddrOut = ALUResultIn[ADDR_W+1:2]
//  TIMEOUT  16  max cycles in WAIT without MemReady before abort (>=1)
// PORTS
//  Clk            in   1   clock, rising edge
//  Rst_n          in   1   async active-low reset
//  MemReadIn      in   1   load request from EX/MEM
//  MemWriteIn     in   1   store request from EX/MEM
//  bytes2LoadIn   in   2   load size: 00 word, 01 half, 10 byte, 11 treated as word
//  bytes2StoreIn  in   2   store size, same encoding
//  LoadSignedIn   in   1   1 = sign-extend byte/half loads, 0 = zero-extend
//  ALUResultIn    in   32  byte address
//  MemWriteDataIn in   32  store data, right-justified
//  MemReqOut      out  1   memory request, held until MemReady
//  MemWeOut       out  1   1 = write, 0 = read; valid while MemReqOut
//  MemBeOut       out  4   byte enables; bit i = bits [8i+7:8i]
//  MemAddrOut     out  ADDR_W  word address
//  MemWdataOut    out  32  lane-replicated write data
//  MemRdataIn     in   32  read data, valid when MemReadyIn
//  MemReadyIn     in   1   completes current request at the rising edge
//  LoadDataOut    out  32  extended load result, registered
//  StallOut       out  1   1 = EX/MEM and earlier stages must hold
//  AlignErrOut    out  1   one-cycle pulse: misaligned or Read+Write both set
//  TimeoutErrOut  out  1   one-cycle pulse: TIMEOUT reached
// BEHAVIOUR
//  Reset (Rst_n=0, async): state IDLE, timer 0, all outputs 0 (incl. StallOut), immediately.
//  A memory request in flight at reset is abandoned; memory must tolerate a dropped MemReqOut.
//  States: IDLE, WAIT, DONE, ERR.
//  IDLE: op = MemReadIn|MemWriteIn. No op -> stay, Stall=0.
//   op, aligned, not both -> Stall=1, latch addr/size/data/we/sign, next WAIT.
//   Misaligned (half: addr[0]!=0; word: addr[1:0]!=0) or Read&Write -> Stall=1, next ERR.
//  WAIT: MemReq=1; We/Be/Addr/Wdata stable from latched values.
//   Stall=1. Timer increments each cycle.
//   MemReady=1 at edge -> capture extended load (reads), next DONE, MemReq drops next cycle.
//   Zero-wait memory: Ready in the first WAIT cycle is legal.
//   Timer reaches TIMEOUT without Ready -> next ERR with timeout cause.
//  DONE: Stall=0, LoadDataOut valid (held until next load completes), next IDLE.
//   Pipeline advances on this edge, so the same instruction is never re-issued.
//  ERR: Stall=0; exactly one of AlignErrOut/TimeoutErrOut=1; LoadDataOut=0; no request issued; next IDLE.
//  Minimum cost per memory op: 2 stall cycles (IDLE + one WAIT).
//  Lanes (little-endian): off = addr[1:0].
//   Byte: Be = 4'b0001<<off, Wdata = {4{d[7:0]}}.
//   Half: Be = 4'b0011<<off, Wdata = {2{d[15:0]}}.
//   Word: Be = 4'b1111.
//   Reads also drive Be per size.
//  Load extract: r = MemRdataIn >> (8*off); byte/half extended from bit 7/15 by LoadSignedIn.
//  Word loads pass through unchanged.
//  Timer clears on entry to WAIT; no wrap (saturates at TIMEOUT).
// TESTING
//  1 sw addr 0x100, data 0xDEADBEEF, Ready after 2 WAIT cycles ->
//    Addr 0x40, Be 1111, We 1, Wdata 0xDEADBEEF; Stall high 3 cycles, then DONE.
//  2 sb addr 0x103, data 0x000000A5, zero-wait Ready -> Be 1000, Wdata 0xA5A5A5A5;
//    Stall high exactly 2 cycles.
//  3 lb addr 0x102, Rdata 0x12F03456 -> LoadDataOut 0xFFFFFFF0 when signed,
//    0x000000F0 when unsigned.
//  4 lh addr 0x101 -> no MemReq ever; AlignErrOut pulses 1 cycle; LoadDataOut 0.
//    MemRead=MemWrite=1 also gives AlignErrOut.
//  5 lw with Ready held 0, TIMEOUT=16 -> MemReq high 16 cycles, then TimeoutErrOut pulse;
//    Stall drops; next op accepted.
//  6 Rst_n low mid-WAIT -> MemReq/Stall go 0 asynchronously; after release a new sw
//    completes normally.

Source files
------------

// File: rtl/mem_stage_access_unit.sv
// MEM-stage access unit: turns EX/MEM load/store controls into a req/ready word-memory access.
// Latency: 2 stall cycles minimum per op (IDLE accept + one WAIT); LoadDataOut registered into DONE.
// Backpressure: StallOut holds earlier stages until DONE/ERR; MemReqOut held until MemReadyIn or timeout.
module mem_stage_access_unit #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              MemReadIn,
  input  logic              MemWriteIn,
  input  logic [1:0]        bytes2LoadIn,
  input  logic [1:0]        bytes2StoreIn,
  input  logic              LoadSignedIn,
  input  logic [31:0]       ALUResultIn,
  input  logic [31:0]       MemWriteDataIn,
  output logic              MemReqOut,
  output logic              MemWeOut,
  output logic [3:0]        MemBeOut,
  output logic [ADDR_W-1:0] MemAddrOut,
  output logic [31:0]       MemWdataOut,
  input  logic [31:0]       MemRdataIn,
  input  logic              MemReadyIn,
  output logic [31:0]       LoadDataOut,
  output logic              StallOut,
  output logic              AlignErrOut,
  output logic              TimeoutErrOut
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              we_q, sign_q, err_to_q, err_to_d;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, load_q;
  logic [1:0]        size_q, off_q;
  logic              accept, capture, to_err;

  // Incoming operation decode (size follows the active op; both-set is an error anyway)
  logic        op, both, misalign;
  logic [1:0]  size_in, off_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic        unused_addr_hi;

  assign op      = MemReadIn | MemWriteIn;
  assign both    = MemReadIn & MemWriteIn;
  assign size_in = MemWriteIn ? bytes2StoreIn : bytes2LoadIn;
  assign off_in  = ALUResultIn[1:0];
  assign unused_addr_hi = ^ALUResultIn[31:ADDR_W+2];

  // Lane steering for the incoming op: alignment, byte enables, replicated write data
  always_comb begin
    misalign = 1'b0;
    be_in    = 4'b1111;
    wdata_in = MemWriteDataIn;
    case (size_in)
      2'b10: begin
        be_in    = 4'b0001 << off_in;
        wdata_in = {4{MemWriteDataIn[7:0]}};
      end
      2'b01: begin
        misalign = off_in[0];
        be_in    = 4'b0011 << off_in;
        wdata_in = {2{MemWriteDataIn[15:0]}};
      end
      default: misalign = |off_in;
    endcase
  end

  // Load extraction from the returned word using the latched offset/size/sign
  logic [31:0] r_sh, ld_ext;
  assign r_sh = MemRdataIn >> {off_q, 3'b000};
  always_comb begin
    ld_ext = MemRdataIn;
    case (size_q)
      2'b10:   ld_ext = sign_q ? {{24{r_sh[7]}}, r_sh[7:0]}   : {24'b0, r_sh[7:0]};
      2'b01:   ld_ext = sign_q ? {{16{r_sh[15]}}, r_sh[15:0]} : {16'b0, r_sh[15:0]};
      default: ld_ext = MemRdataIn;
    endcase
  end

  // State and timer registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic: accept/reject in IDLE, wait for ready or timeout, single-cycle DONE/ERR
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    err_to_d = 1'b0;
    accept   = 1'b0;
    capture  = 1'b0;
    to_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op) begin
          if (both || misalign) begin
            state_d = S_ERR;
            to_err  = 1'b1;
          end else begin
            state_d = S_WAIT;
            timer_d = '0;
            accept  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        timer_d = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);
        if (MemReadyIn) begin
          state_d = S_DONE;
          capture = ~we_q;
        end else if (timer_q == TLAST) begin
          state_d  = S_ERR;
          err_to_d = 1'b1;
          to_err   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, error cause and load result registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      we_q     <= 1'b0;
      sign_q   <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      off_q    <= '0;
      err_to_q <= 1'b0;
      load_q   <= '0;
    end else begin
      if (accept) begin
        we_q    <= MemWriteIn;
        sign_q  <= LoadSignedIn;
        be_q    <= be_in;
        addr_q  <= ALUResultIn[ADDR_W+1:2];
        wdata_q <= wdata_in;
        size_q  <= size_in;
        off_q   <= off_in;
      end
      if (to_err) begin
        err_to_q <= err_to_d;
        load_q   <= '0;
      end else if (capture) begin
        load_q <= ld_ext;
      end
    end
  end

  // Request bus is only driven while the request is live; stall is forced low during reset
  assign MemReqOut     = (state_q == S_WAIT);
  assign MemWeOut      = MemReqOut & we_q;
  assign MemBeOut      = MemReqOut ? be_q    : '0;
  assign MemAddrOut    = MemReqOut ? addr_q  : '0;
  assign MemWdataOut   = MemReqOut ? wdata_q : '0;
  assign StallOut      = Rst_n & (MemReqOut | ((state_q == S_IDLE) & op));
  assign AlignErrOut   = (state_q == S_ERR) & ~err_to_q;
  assign TimeoutErrOut = (state_q == S_ERR) &  err_to_q;
  assign LoadDataOut   = load_q;

endmodule
